// File: rtl/lif_pkg.sv
// Shared codes, reset constants and FSM encoding for the LIF neuron scheduler.
package lif_pkg;

    localparam int unsigned CFG_FIELD_W = 2;
    localparam int unsigned CFG_DATA_W  = 8;
    localparam int unsigned SHIFT_W     = 3;

    localparam logic [CFG_FIELD_W-1:0] CFG_W     = 2'd0;
    localparam logic [CFG_FIELD_W-1:0] CFG_SHIFT = 2'd1;
    localparam logic [CFG_FIELD_W-1:0] CFG_TETA  = 2'd2;
    localparam logic [CFG_FIELD_W-1:0] CFG_CLR   = 2'd3;

    localparam int W_RST     = 1;
    localparam int SHIFT_RST = 0;
    localparam int TETA_RST  = -5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lif_neuron_scheduler_if.sv
// Tile-side configuration / step handshake bundle of the LIF neuron scheduler.
interface lif_neuron_scheduler_if
    import lif_pkg::*;
#(
    parameter int unsigned N_STAGES = 2,
    parameter int unsigned NEURONS  = 4
);
    localparam int unsigned INPUTS = 2 ** N_STAGES;
    localparam int unsigned IDX_W  = $clog2(NEURONS);

    logic                   cfg_we;
    logic [IDX_W-1:0]       cfg_sel;
    logic [CFG_FIELD_W-1:0] cfg_field;
    logic [CFG_DATA_W-1:0]  cfg_data;
    logic                   cfg_ready;
    logic                   step_valid;
    logic [INPUTS-1:0]      step_x;
    logic                   step_ready;
    logic                   out_valid;
    logic [NEURONS-1:0]     spike_vec;

    modport master (
        output cfg_we, cfg_sel, cfg_field, cfg_data, step_valid, step_x,
        input  cfg_ready, step_ready, out_valid, spike_vec
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_field, cfg_data, step_valid, step_x,
        output cfg_ready, step_ready, out_valid, spike_vec
    );

endinterface

// File: rtl/lif_state_bank.sv
// Per-neuron configuration and state registers: config write port,
// one indexed read port and a state writeback port at the same index.
module lif_state_bank
    import lif_pkg::*;
#(
    parameter int unsigned INPUTS  = 4,
    parameter int unsigned OUT_W   = 4,
    parameter int unsigned NEURONS = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_en,
    input  logic [IDX_W-1:0]       cfg_sel,
    input  logic [CFG_FIELD_W-1:0] cfg_field,
    input  logic [CFG_DATA_W-1:0]  cfg_data,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [INPUTS-1:0]      rd_w,
    output logic [SHIFT_W-1:0]     rd_shift,
    output logic [OUT_W-1:0]       rd_teta,
    output logic [OUT_W-1:0]       rd_u,
    output logic                   rd_was_spike,
    input  logic                   wb_en,
    input  logic [OUT_W-1:0]       wb_u,
    input  logic                   wb_spike
);

    logic [INPUTS-1:0]  w_q     [NEURONS];
    logic [SHIFT_W-1:0] shift_q [NEURONS];
    logic [OUT_W-1:0]   teta_q  [NEURONS];
    logic [OUT_W-1:0]   u_q     [NEURONS];
    logic               ws_q    [NEURONS];

    // Only the low bits of cfg_data matter for each field.
    logic unused_cfg_data_c;
    assign unused_cfg_data_c = ^cfg_data;

    // Config writes happen only in IDLE and writeback only in RUN, so they never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NEURONS); i++) begin
                w_q[i]     <= INPUTS'(W_RST);
                shift_q[i] <= SHIFT_W'(SHIFT_RST);
                teta_q[i]  <= OUT_W'(TETA_RST);
                u_q[i]     <= '0;
                ws_q[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(NEURONS); i++) begin
                if (cfg_en && cfg_sel == IDX_W'(i)) begin
                    case (cfg_field)
                        CFG_W:     w_q[i]     <= cfg_data[INPUTS-1:0];
                        CFG_SHIFT: shift_q[i] <= cfg_data[SHIFT_W-1:0];
                        CFG_TETA:  teta_q[i]  <= cfg_data[OUT_W-1:0];
                        CFG_CLR: begin
                            u_q[i]  <= '0;
                            ws_q[i] <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                if (wb_en && rd_idx == IDX_W'(i)) begin
                    u_q[i]  <= wb_u;
                    ws_q[i] <= wb_spike;
                end
            end
        end
    end

    assign rd_w         = w_q[rd_idx];
    assign rd_shift     = shift_q[rd_idx];
    assign rd_teta      = teta_q[rd_idx];
    assign rd_u         = u_q[rd_idx];
    assign rd_was_spike = ws_q[rd_idx];

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexes one combinational LIF core over NEURONS virtual neurons,
// one neuron per clock, and returns a spike vector per accepted step.
module lif_neuron_scheduler
    import lif_pkg::*;
#(
    parameter int unsigned N_STAGES = 2,
    parameter int unsigned INPUTS   = 2 ** N_STAGES,
    parameter int unsigned OUT_W    = N_STAGES + 2,
    parameter int unsigned NEURONS  = 4,
    parameter int unsigned IDX_W    = $clog2(NEURONS)
) (
    input  logic                clk,
    input  logic                reset,
    lif_neuron_scheduler_if.slave bus,
    output logic [INPUTS-1:0]   core_w,
    output logic [INPUTS-1:0]   core_x,
    output logic [SHIFT_W-1:0]  core_shift,
    output logic [OUT_W-1:0]    core_prev_u,
    output logic [OUT_W-1:0]    core_minus_teta,
    output logic                core_was_spike,
    input  logic [OUT_W-1:0]    core_u,
    input  logic                core_spike
);

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [INPUTS-1:0]  x_q, x_next;
    logic [NEURONS-1:0] spike_q, spike_next;
    logic               out_valid_q;
    logic               ready_q;
    logic               cfg_en_c;
    logic               wb_en_c;

    logic [INPUTS-1:0]  rd_w;
    logic [SHIFT_W-1:0] rd_shift;
    logic [OUT_W-1:0]   rd_teta;
    logic [OUT_W-1:0]   rd_u;
    logic               rd_was_spike;

    // ready_q mirrors state==IDLE, so it also gates config writes.
    assign cfg_en_c = ready_q && bus.cfg_we && (32'(bus.cfg_sel) < 32'(NEURONS));

    lif_state_bank #(
        .INPUTS  (INPUTS),
        .OUT_W   (OUT_W),
        .NEURONS (NEURONS),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk          (clk),
        .reset        (reset),
        .cfg_en       (cfg_en_c),
        .cfg_sel      (bus.cfg_sel),
        .cfg_field    (bus.cfg_field),
        .cfg_data     (bus.cfg_data),
        .rd_idx       (idx),
        .rd_w         (rd_w),
        .rd_shift     (rd_shift),
        .rd_teta      (rd_teta),
        .rd_u         (rd_u),
        .rd_was_spike (rd_was_spike),
        .wb_en        (wb_en_c),
        .wb_u         (core_u),
        .wb_spike     (core_spike)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            x_q         <= '0;
            spike_q     <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            x_q         <= x_next;
            spike_q     <= spike_next;
            out_valid_q <= (state_next == DONE);
            ready_q     <= (state_next == IDLE);
        end
    end

    // Next state, neuron sequencing and core operand muxing.
    always_comb begin
        state_next      = state;
        idx_next        = idx;
        x_next          = x_q;
        spike_next      = spike_q;
        wb_en_c         = 1'b0;
        core_w          = '0;
        core_x          = '0;
        core_shift      = '0;
        core_prev_u     = '0;
        core_minus_teta = '0;
        core_was_spike  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.step_valid) begin
                    x_next     = bus.step_x;
                    idx_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                wb_en_c         = 1'b1;
                core_w          = rd_w;
                core_x          = x_q;
                core_shift      = rd_shift;
                core_prev_u     = rd_u;
                core_minus_teta = rd_teta;
                core_was_spike  = rd_was_spike;
                spike_next[idx] = core_spike;
                if (idx == IDX_W'(NEURONS - 1)) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.cfg_ready  = ready_q;
    assign bus.step_ready = ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.spike_vec  = spike_q;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Directed bench: core stub returns u=k+3, spike=k[0] for slot k; checks operands per slot.
module tb_lif_neuron_scheduler;
    import lif_pkg::*;

    localparam int unsigned NEURONS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lif_neuron_scheduler_if #(.N_STAGES(2), .NEURONS(NEURONS)) bus ();

    logic [3:0] core_w, core_x, core_prev_u, core_minus_teta, core_u;
    logic [2:0] core_shift;
    logic       core_was_spike, core_spike;

    lif_neuron_scheduler #(.N_STAGES(2), .NEURONS(NEURONS)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .core_w          (core_w),
        .core_x          (core_x),
        .core_shift      (core_shift),
        .core_prev_u     (core_prev_u),
        .core_minus_teta (core_minus_teta),
        .core_was_spike  (core_was_spike),
        .core_u          (core_u),
        .core_spike      (core_spike)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] o_w [NEURONS];
    logic [3:0] o_x [NEURONS];
    logic [3:0] o_pu[NEURONS];
    logic [3:0] o_th[NEURONS];
    logic [2:0] o_sh[NEURONS];
    logic       o_ws[NEURONS];
    logic       o_ov;
    logic [3:0] o_sv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_slot(input string tag, input int k, input int w, input int x,
                              input int sh, input int pu, input int th, input int ws);
        check($sformatf("%s k%0d w", tag, k),    32'(o_w[k]),  32'(w));
        check($sformatf("%s k%0d x", tag, k),    32'(o_x[k]),  32'(x));
        check($sformatf("%s k%0d sh", tag, k),   32'(o_sh[k]), 32'(sh));
        check($sformatf("%s k%0d pu", tag, k),   32'(o_pu[k]), 32'(pu));
        check($sformatf("%s k%0d teta", tag, k), 32'(o_th[k]), 32'(th));
        check($sformatf("%s k%0d ws", tag, k),   32'(o_ws[k]), 32'(ws));
    endtask

    task automatic cfg_write(input int sel, input logic [1:0] field, input logic [7:0] data);
        @(negedge clk);
        check("cfg_ready", 32'(bus.cfg_ready), 32'd1);
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = 2'(sel);
        bus.cfg_field = field;
        bus.cfg_data  = data;
        @(posedge clk);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    // One full step; optional dropped write in RUN, simultaneous write at acceptance, or reset abort.
    task automatic run_step(input logic [3:0] x, input bit mid_cfg, input bit sim_cfg,
                            input int sim_sel, input logic [1:0] sim_field, input int abort_at);
        @(negedge clk);
        check("step_ready", 32'(bus.step_ready), 32'd1);
        bus.step_valid = 1'b1;
        bus.step_x     = x;
        if (sim_cfg) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_sel   = 2'(sim_sel);
            bus.cfg_field = sim_field;
            bus.cfg_data  = 8'h00;
        end
        @(posedge clk);
        for (int k = 0; k < int'(NEURONS); k++) begin
            @(negedge clk);
            bus.step_valid = 1'b0;
            bus.step_x     = ~x;
            bus.cfg_we     = 1'b0;
            if (mid_cfg && k == 1) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_sel   = 2'd0;
                bus.cfg_field = CFG_SHIFT;
                bus.cfg_data  = 8'h07;
            end
            core_u     = 4'(k + 3);
            core_spike = k[0];
            #1;
            o_w[k]  = core_w;
            o_x[k]  = core_x;
            o_sh[k] = core_shift;
            o_pu[k] = core_prev_u;
            o_th[k] = core_minus_teta;
            o_ws[k] = core_was_spike;
            check($sformatf("out_valid in run k%0d", k), 32'(bus.out_valid), 32'd0);
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                check("abort out_valid", 32'(bus.out_valid), 32'd0);
                check("abort spike_vec", 32'(bus.spike_vec), 32'd0);
                check("abort idle", 32'(bus.step_ready), 32'd1);
                check("abort core_w", 32'(core_w), 32'd0);
                @(posedge clk);
                @(negedge clk);
                check("abort out_valid late", 32'(bus.out_valid), 32'd0);
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.cfg_we = 1'b0;
        o_ov = bus.out_valid;
        o_sv = bus.spike_vec;
        check("core_w after run", 32'(core_w), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.cfg_we     = 1'b0;
        bus.cfg_sel    = '0;
        bus.cfg_field  = '0;
        bus.cfg_data   = '0;
        bus.step_valid = 1'b0;
        bus.step_x     = '0;
        core_u         = '0;
        core_spike     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst step_ready", 32'(bus.step_ready), 32'd1);
        check("rst cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst spike_vec", 32'(bus.spike_vec), 32'd0);
        check("rst core_w", 32'(core_w), 32'd0);
        check("rst core_teta", 32'(core_minus_teta), 32'd0);
        check("rst core_x", 32'(core_x), 32'd0);

        // Defaults from reset
        run_step(4'hF, 1'b0, 1'b0, 0, 2'd0, -1);
        for (int k = 0; k < 4; k++) check_slot("s1", k, 1, 'hF, 0, 0, 'hB, 0);
        check("s1 out_valid", 32'(o_ov), 32'd1);
        check("s1 spike_vec", 32'(o_sv), 32'b1010);

        // State carried from previous step
        run_step(4'h5, 1'b0, 1'b0, 0, 2'd0, -1);
        for (int k = 0; k < 4; k++) check_slot("s2", k, 1, 'h5, 0, k + 3, 'hB, k % 2);
        check("s2 spike_vec", 32'(o_sv), 32'b1010);

        // Weight and threshold writes to neuron 2
        cfg_write(2, CFG_W, 8'h0C);
        cfg_write(2, CFG_TETA, 8'h0E);
        run_step(4'h3, 1'b0, 1'b0, 0, 2'd0, -1);
        for (int k = 0; k < 4; k++)
            check_slot("s3", k, (k == 2) ? 'hC : 1, 'h3, 0, k + 3, (k == 2) ? 'hE : 'hB, k % 2);

        // Write during RUN is dropped
        run_step(4'hA, 1'b1, 1'b0, 0, 2'd0, -1);
        run_step(4'h6, 1'b0, 1'b0, 0, 2'd0, -1);
        for (int k = 0; k < 4; k++)
            check_slot("s4", k, (k == 2) ? 'hC : 1, 'h6, 0, k + 3, (k == 2) ? 'hE : 'hB, k % 2);

        // Shift write takes low 3 bits
        cfg_write(3, CFG_SHIFT, 8'hFD);
        run_step(4'h9, 1'b0, 1'b0, 0, 2'd0, -1);
        for (int k = 0; k < 4; k++) check("s5 sh", 32'(o_sh[k]), (k == 3) ? 32'd5 : 32'd0);

        // Clear of neuron 1 together with step acceptance
        run_step(4'h7, 1'b0, 1'b1, 1, CFG_CLR, -1);
        for (int k = 0; k < 4; k++)
            check_slot("s6", k, (k == 2) ? 'hC : 1, 'h7, (k == 3) ? 5 : 0,
                       (k == 1) ? 0 : k + 3, (k == 2) ? 'hE : 'hB, (k == 1) ? 0 : k % 2);
        check("s6 spike_vec", 32'(o_sv), 32'b1010);

        // Reset at idx==2 aborts the step
        run_step(4'hF, 1'b0, 1'b0, 0, 2'd0, 2);
        run_step(4'hC, 1'b0, 1'b0, 0, 2'd0, -1);
        for (int k = 0; k < 4; k++) check_slot("s8", k, 1, 'hC, 0, 0, 'hB, 0);
        check("s8 out_valid", 32'(o_ov), 32'd1);
        check("s8 spike_vec", 32'(o_sv), 32'b1010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lif_neuron_scheduler.md
Name: lif_neuron_scheduler

Overview:
- Time-multiplexes one combinational LIF neuron core across NEURONS virtual neurons.
- Holds per-neuron configuration (weights, leak shift, negative threshold) and per-neuron state (membrane potential, last spike).
- Sequences one neuron per clock through the core on each accepted input step, then returns a spike vector.
- Sits between the tile I/O pins and the neuron core; it replaces the single fixed register set currently in front of the core.

Parameters:
- N_STAGES, 2, adder-tree depth of the core.
- INPUTS, 2**N_STAGES, synaptic inputs per neuron; also the weight width.
- OUT_W, N_STAGES+2, membrane-potential / threshold width.
- NEURONS, 4, number of virtual neurons; range 2..8.
- IDX_W, $clog2(NEURONS), neuron index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  configuration write strobe
- cfg_sel  in  IDX_W  target neuron index
- cfg_field  in  2  0=weights, 1=shift, 2=minus_teta, 3=clear state
- cfg_data  in  8  write data; low bits used per field
- cfg_ready  out  1  high when a write will be accepted
- step_valid  in  1  request to evaluate all neurons
- step_x  in  INPUTS  input spike vector for this step
- step_ready  out  1  high when a step will be accepted
- out_valid  out  1  one-cycle pulse: step finished
- spike_vec  out  NEURONS  per-neuron is_spike from the last step
- core_w  out  INPUTS  to core w
- core_x  out  INPUTS  to core x
- core_shift  out  3  to core shift
- core_prev_u  out  OUT_W  to core previus_u
- core_minus_teta  out  OUT_W  to core minus_teta
- core_was_spike  out  1  to core was_spike
- core_u  in  OUT_W  from core u_out
- core_spike  in  1  from core is_spike

Behaviour:
- Reset values (all neurons):
  - w=1, shift=0, minus_teta=-5 (4'b1011 at OUT_W=4), u=0, was_spike=0.
  - State IDLE; spike_vec=0; out_valid=0; idx=0; latched x=0.
  - All core_* outputs = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - step_ready=1, cfg_ready=1.
  - If step_valid: latch step_x, set idx=0, go to RUN.
- RUN:
  - Lasts NEURONS cycles, one per neuron.
  - Each cycle, core_* outputs are driven combinationally from the neuron[idx] registers and latched x.
  - At the clock edge: u[idx]<=core_u, was_spike[idx]<=core_spike, spike_vec[idx]<=core_spike.
  - idx increments; at idx==NEURONS-1, go to DONE.
- DONE:
  - Lasts one cycle; out_valid=1; then return to IDLE.
  - spike_vec holds its value until the next step overwrites it bit by bit.
- Latency:
  - Step accepted at edge t.
  - Neuron k is evaluated in cycle t+1+k.
  - out_valid is high in cycle t+1+NEURONS.
  - The next step can be accepted at edge t+2+NEURONS.
- Outside RUN, core_* outputs = 0.
- Config writes:
  - Applied at the edge only when cfg_ready (IDLE); cfg_we outside IDLE is dropped silently.
  - Field 0: w<=cfg_data[INPUTS-1:0].
  - Field 1: shift<=cfg_data[2:0].
  - Field 2: minus_teta<=cfg_data[OUT_W-1:0].
  - Field 3: u<=0, was_spike<=0.
  - cfg_sel>=NEURONS: write ignored.
- Simultaneous cfg_we and step_valid in IDLE: both are accepted, and the write is visible to the step's evaluation.
- Arithmetic: the scheduler does none; core_u is stored unmodified and wraps at OUT_W bits as the core defines.
- Reset asserted mid-RUN or in DONE: the step is aborted and every register returns to its reset value; no out_valid.
- step_x is sampled only at acceptance; changes during RUN have no effect.

Decomposition:
- Shared package lif_pkg holds:
  - Field codes CFG_W, CFG_SHIFT, CFG_TETA, CFG_CLR.
  - Reset constants W_RST=1, SHIFT_RST=0, TETA_RST=-5.
  - The FSM state enum.
- One sub-module, lif_state_bank: per-neuron register file with a config write port, an idx read port and a state writeback port.
- The FSM and core muxing stay in the top.
- The core itself is instantiated by the tile top, not inside this block.

Test Plan:
- Reset, then step with step_x=4'b1111 against a core stub (core_u=idx+3, core_spike=idx[0]):
  - Across the 4 RUN cycles: core_w=1, core_minus_teta=4'hB, core_prev_u=0, core_x=4'hF.
  - out_valid at cycle 5 after acceptance; spike_vec=4'b1010.
- Second step, same stub:
  - core_prev_u for neuron k equals k+3.
  - core_was_spike sequence is 0,1,0,1.
- Write field 0 data 8'h0C to neuron 2, then field 2 data 8'h0E, then step:
  - In slot 2, core_w=4'hC and core_minus_teta=4'hE.
  - Other slots are unchanged.
- cfg_we during RUN (field 1, data 7, neuron 0) is dropped; the next step shows core_shift=0 in slot 0.
- cfg_we (field 3, neuron 1) together with step_valid in IDLE: that step shows core_prev_u=0 and core_was_spike=0 in slot 1.
- Reset asserted in the RUN cycle with idx=2:
  - No out_valid; spike_vec=0; state is IDLE the following cycle.
  - The next step shows reset defaults in every slot.
